ecc_op_controller: RTL and testbench

- Sequences one ECC operation after software writes the CTRL register over APB.
- Decodes the operation code, launches the encoder and/or decoder, and inserts the noise step for full-channel runs.
- Reports completion, busy status, error count and timeout.
- Sits between the APB register bank and the encoder, noise and decoder datapaths of the ECC_ENC_DEC top.

---
 rtl/ecc_op_controller_if.sv | 43 ++++
 rtl/ecc_op_controller.sv | 199 +++++++++++++++++++
 tb/tb_ecc_op_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_op_controller_if.sv
// Handshake bundle between the APB register bank, the ECC datapaths and
// the operation controller.
//   ctrl_wr, CTRL, CODEWORD_WIDTH  : register-bank side (launch request)
//   enc_done, dec_done,
//   dec_num_of_errors              : datapath completion / verdict
//   enc_start, noise_en, dec_start,
//   dec_src_sel, width_sel         : datapath control
//   busy, operation_done,
//   num_of_errors, timeout,
//   ctrl_reject                    : status back to software
// slave  = controller view, master = register bank / datapath view.
interface ecc_op_controller_if #(
  parameter int AMBA_WORD = 32
);
  logic                 ctrl_wr;
  logic [AMBA_WORD-1:0] CTRL;
  logic [AMBA_WORD-1:0] CODEWORD_WIDTH;
  logic                 enc_done;
  logic                 dec_done;
  logic [1:0]           dec_num_of_errors;
  logic                 enc_start;
  logic                 noise_en;
  logic                 dec_start;
  logic                 dec_src_sel;
  logic [1:0]           width_sel;
  logic                 busy;
  logic                 operation_done;
  logic [1:0]           num_of_errors;
  logic                 timeout;
  logic                 ctrl_reject;

  modport master (
    output ctrl_wr, CTRL, CODEWORD_WIDTH, enc_done, dec_done, dec_num_of_errors,
    input  enc_start, noise_en, dec_start, dec_src_sel, width_sel, busy,
           operation_done, num_of_errors, timeout, ctrl_reject
  );

  modport slave (
    input  ctrl_wr, CTRL, CODEWORD_WIDTH, enc_done, dec_done, dec_num_of_errors,
    output enc_start, noise_en, dec_start, dec_src_sel, width_sel, busy,
           operation_done, num_of_errors, timeout, ctrl_reject
  );
endinterface

// File: rtl/ecc_op_controller.sv
// Sequencer for a single ECC operation (encode, decode or full channel).
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - ecc_op_controller_if.slave (launch request, datapath handshakes,
//          status outputs; all outputs registered)
//
// state  | meaning
// IDLE   | waiting for a CTRL write
// ENC    | encoder launched, waiting for enc_done or timeout
// NOISE  | one cycle of noise injection (full channel only)
// DEC    | decoder launched, waiting for dec_done or timeout
// DONE   | one-cycle completion, result valid
module ecc_op_controller #(
  parameter int AMBA_WORD      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                rst,
  ecc_op_controller_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENC   = 3'd1;
  localparam logic [2:0] S_NOISE = 3'd2;
  localparam logic [2:0] S_DEC   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_FULL = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_opcode;
  logic       r_enc_done;
  logic       r_dec_done;
  logic [1:0] r_dec_errs;

  logic       r_enc_start;
  logic       r_noise_en;
  logic       r_dec_start;
  logic       r_dec_src_sel;
  logic [1:0] r_width_sel;
  logic       r_busy;
  logic       r_op_done;
  logic [1:0] r_num_err;
  logic       r_timeout;
  logic       r_ctrl_reject;

  logic [AMBA_WORD-1:0] w_ctrl;
  logic [AMBA_WORD-1:0] w_cw;
  logic [1:0]           w_opcode;
  logic [1:0]           w_width;
  logic                 w_tc;
  logic                 w_enc_hit;
  logic                 w_dec_hit;
  logic [1:0]           w_dec_errs;
  logic                 w_unused_bits;

  assign w_ctrl        = bus.CTRL;
  assign w_cw          = bus.CODEWORD_WIDTH;
  assign w_opcode      = w_ctrl[1:0];
  assign w_width       = w_cw[1:0];
  assign w_unused_bits = ^{w_ctrl[AMBA_WORD-1:2], w_cw[AMBA_WORD-1:2]};

  // Done pulses are registered before the FSM acts on them. On the last
  // wait cycle the raw pulse is also honoured, so a done that lands exactly
  // on the timeout cycle wins over the abort.
  assign w_tc       = (r_cnt == CNT_LAST);
  assign w_enc_hit  = r_enc_done | (w_tc & bus.enc_done);
  assign w_dec_hit  = r_dec_done | (w_tc & bus.dec_done);
  assign w_dec_errs = r_dec_done ? r_dec_errs : bus.dec_num_of_errors;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_opcode      <= OP_ENC;
      r_enc_done    <= 1'b0;
      r_dec_done    <= 1'b0;
      r_dec_errs    <= 2'b00;
      r_enc_start   <= 1'b0;
      r_noise_en    <= 1'b0;
      r_dec_start   <= 1'b0;
      r_dec_src_sel <= 1'b0;
      r_width_sel   <= 2'b00;
      r_busy        <= 1'b0;
      r_op_done     <= 1'b0;
      r_num_err     <= 2'b00;
      r_timeout     <= 1'b0;
      r_ctrl_reject <= 1'b0;
    end else begin
      r_enc_start   <= 1'b0;
      r_noise_en    <= 1'b0;
      r_dec_start   <= 1'b0;
      r_op_done     <= 1'b0;
      r_ctrl_reject <= 1'b0;
      r_enc_done    <= bus.enc_done & (r_state == S_ENC);
      r_dec_done    <= bus.dec_done & (r_state == S_DEC);
      r_dec_errs    <= bus.dec_num_of_errors;
      r_cnt         <= r_cnt + 8'd1;

      case (r_state)
        S_IDLE: begin
          r_cnt <= 8'd0;
          if (bus.ctrl_wr) begin
            if (w_opcode == OP_ILL) begin
              r_ctrl_reject <= 1'b1;
            end else begin
              r_opcode      <= w_opcode;
              r_width_sel   <= (w_width == 2'b11) ? 2'b10 : w_width;
              r_num_err     <= 2'b00;
              r_timeout     <= 1'b0;
              r_busy        <= 1'b1;
              r_dec_src_sel <= (w_opcode == OP_FULL);
              if (w_opcode == OP_DEC) begin
                r_state     <= S_DEC;
                r_dec_start <= 1'b1;
              end else begin
                r_state     <= S_ENC;
                r_enc_start <= 1'b1;
              end
            end
          end
        end
        S_ENC: begin
          if (w_enc_hit) begin
            r_cnt <= 8'd0;
            if (r_opcode == OP_FULL) begin
              r_state    <= S_NOISE;
              r_noise_en <= 1'b1;
            end else begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_op_done <= 1'b1;
            end
          end else if (w_tc) begin
            r_cnt     <= 8'd0;
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_op_done <= 1'b1;
            r_timeout <= 1'b1;
            r_num_err <= 2'b11;
          end
        end
        S_NOISE: begin
          r_cnt       <= 8'd0;
          r_state     <= S_DEC;
          r_dec_start <= 1'b1;
        end
        S_DEC: begin
          if (w_dec_hit) begin
            r_cnt     <= 8'd0;
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_op_done <= 1'b1;
            r_num_err <= w_dec_errs;
          end else if (w_tc) begin
            r_cnt     <= 8'd0;
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_op_done <= 1'b1;
            r_timeout <= 1'b1;
            r_num_err <= 2'b11;
          end
        end
        S_DONE: begin
          r_cnt   <= 8'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= 8'd0;
          r_state <= S_IDLE;
        end
      endcase

      // DONE still counts as occupied: a write there is refused.
      if (bus.ctrl_wr && (r_state != S_IDLE)) begin
        r_ctrl_reject <= 1'b1;
      end
    end
  end

  assign bus.enc_start      = r_enc_start;
  assign bus.noise_en       = r_noise_en;
  assign bus.dec_start      = r_dec_start;
  assign bus.dec_src_sel    = r_dec_src_sel;
  assign bus.width_sel      = r_width_sel;
  assign bus.busy           = r_busy;
  assign bus.operation_done = r_op_done;
  assign bus.num_of_errors  = r_num_err;
  assign bus.timeout        = r_timeout;
  assign bus.ctrl_reject    = r_ctrl_reject;

endmodule

// File: tb/tb_ecc_op_controller.sv
module tb_ecc_op_controller;
  localparam int T = 64;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [1:0] held_err;
  logic       held_to;

  ecc_op_controller_if #(.AMBA_WORD(32)) bus ();

  ecc_op_controller #(.AMBA_WORD(32), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] outs();
    return {bus.enc_start, bus.noise_en, bus.dec_start, bus.dec_src_sel, bus.width_sel,
            bus.busy, bus.operation_done, bus.num_of_errors, bus.timeout, bus.ctrl_reject};
  endfunction

  task automatic drive_zero();
    bus.ctrl_wr           = 1'b0;
    bus.CTRL              = '0;
    bus.CODEWORD_WIDTH    = '0;
    bus.enc_done          = 1'b0;
    bus.dec_done          = 1'b0;
    bus.dec_num_of_errors = 2'b00;
  endtask

  // Phase length when done arrives d cycles after start: the result is seen
  // two cycles after the pulse, capped by the timeout window.
  function automatic int phase_len(input int d);
    return (d + 2 < T) ? d + 2 : T;
  endfunction

  // One launch. Cycle 0 carries ctrl_wr; the bench plays the datapaths,
  // answering enc_start/dec_start after d1/d2 cycles and adding stray dones.
  task automatic run_op(input int op, input int wd, input int d1, input int d2,
                        input int errs, input int want_rej, input int gap);
    int exp_es, exp_ns, exp_ds, exp_done, exp_err, exp_to, exp_w, rj, horizon;
    int n_es, n_ns, n_ds, n_dn, n_rej, c_es, c_ns, c_ds, c_dn, c_rej;
    int busy_bad, src_bad, e_at, t_at, w_at;
    exp_es = -1; exp_ns = -1; exp_ds = -1; exp_done = -1; exp_err = 0; exp_to = 0;
    exp_w = (wd == 3) ? 2 : wd;
    if (op == 1) begin
      exp_ds = 1; exp_done = 1 + phase_len(d2);
      exp_to = (d2 >= T); exp_err = exp_to ? 3 : errs;
    end else if (op != 3) begin
      exp_es = 1;
      if (d1 >= T) begin
        exp_done = 1 + T; exp_to = 1; exp_err = 3;
      end else if (op == 0) begin
        exp_done = 1 + phase_len(d1);
      end else begin
        exp_ns = 1 + phase_len(d1); exp_ds = exp_ns + 1;
        exp_done = exp_ds + phase_len(d2);
        exp_to = (d2 >= T); exp_err = exp_to ? 3 : errs;
      end
    end
    rj = -1;
    if (op != 3 && want_rej == 2) rj = ((exp_ds > 0) ? exp_ds : 1) + 1;
    else if (op != 3 && want_rej == 1) rj = $urandom_range(1, exp_done);
    if (gap == 0 && rj >= exp_done) rj = exp_done - 1;
    horizon = (op == 3) ? 5 : exp_done + gap;

    n_es = 0; n_ns = 0; n_ds = 0; n_dn = 0; n_rej = 0;
    c_es = -1; c_ns = -1; c_ds = -1; c_dn = -1; c_rej = -1;
    busy_bad = 0; src_bad = 0; e_at = -1; t_at = -1; w_at = -1;

    tick();
    chk("held_err", bus.num_of_errors, held_err);
    chk("held_to", bus.timeout, held_to);
    bus.ctrl_wr           = 1'b1;
    bus.CTRL              = ($urandom() & ~32'h3) | 32'(op);
    bus.CODEWORD_WIDTH    = ($urandom() & ~32'h3) | 32'(wd);
    bus.enc_done          = 1'b0;
    bus.dec_done          = 1'b0;
    bus.dec_num_of_errors = 2'($urandom());

    for (int c = 1; c <= horizon; c++) begin
      tick();
      if (bus.enc_start) begin n_es++; if (c_es < 0) c_es = c; end
      if (bus.noise_en) begin n_ns++; if (c_ns < 0) c_ns = c; end
      if (bus.dec_start) begin n_ds++; if (c_ds < 0) c_ds = c; end
      if (bus.operation_done) begin n_dn++; if (c_dn < 0) c_dn = c; end
      if (bus.ctrl_reject) begin n_rej++; if (c_rej < 0) c_rej = c; end
      if (bus.busy !== ((op != 3) && (c < exp_done))) busy_bad++;
      if (exp_ds > 0 && c >= exp_ds && c < exp_done && bus.dec_src_sel !== (op == 2)) src_bad++;
      if (c == exp_done) begin
        e_at = int'(bus.num_of_errors); t_at = int'(bus.timeout); w_at = int'(bus.width_sel);
      end
      if (c == 1) begin
        chk("err_after_launch", bus.num_of_errors, (op == 3) ? held_err : 2'b00);
        chk("to_after_launch", bus.timeout, (op == 3) ? held_to : 1'b0);
      end
      bus.ctrl_wr           = (c == rj);
      bus.CTRL              = $urandom();
      bus.CODEWORD_WIDTH    = $urandom();
      bus.enc_done          = 1'b0;
      bus.dec_done          = 1'b0;
      bus.dec_num_of_errors = 2'($urandom());
      if (c_es >= 0 && c == c_es + d1) bus.enc_done = 1'b1;
      else if (c_ds >= 0 && $urandom_range(0, 3) == 0) bus.enc_done = 1'b1;
      if (c_ds >= 0 && c == c_ds + d2) begin
        bus.dec_done = 1'b1;
        bus.dec_num_of_errors = 2'(errs);
      end else if (c_es >= 0 && c_ds < 0 && $urandom_range(0, 3) == 0) begin
        bus.dec_done = 1'b1;
      end
    end

    if (op == 3) begin
      chk("ill_reject_n", n_rej, 1);
      chk("ill_reject_at", c_rej, 1);
      chk("ill_starts", n_es + n_ds + n_ns, 0);
      chk("ill_done", n_dn, 0);
      chk("ill_busy", busy_bad, 0);
    end else begin
      chk("enc_start_at", c_es, exp_es);
      chk("enc_start_n", n_es, (exp_es > 0) ? 1 : 0);
      chk("noise_at", c_ns, exp_ns);
      chk("noise_n", n_ns, (exp_ns > 0) ? 1 : 0);
      chk("dec_start_at", c_ds, exp_ds);
      chk("dec_start_n", n_ds, (exp_ds > 0) ? 1 : 0);
      chk("done_at", c_dn, exp_done);
      chk("done_n", n_dn, 1);
      chk("num_err", e_at, exp_err);
      chk("timeout", t_at, exp_to);
      chk("width_sel", w_at, exp_w);
      chk("busy", busy_bad, 0);
      chk("dec_src_sel", src_bad, 0);
      chk("reject_n", n_rej, (rj >= 0) ? 1 : 0);
      chk("reject_at", c_rej, (rj >= 0) ? rj + 1 : -1);
      held_err = 2'(exp_err);
      held_to  = 1'(exp_to);
    end
  endtask

  task automatic idle_stray();
    int bad;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.busy || bus.enc_start || bus.dec_start || bus.noise_en || bus.operation_done) bad++;
      bus.enc_done = 1'($urandom());
      bus.dec_done = 1'($urandom());
      bus.dec_num_of_errors = 2'($urandom());
    end
    tick();
    if (bus.busy || bus.operation_done) bad++;
    chk("stray_idle", bad, 0);
    chk("stray_err_held", bus.num_of_errors, held_err);
    drive_zero();
  endtask

  task automatic mid_reset();
    int bad;
    tick();
    bus.ctrl_wr = 1'b1; bus.CTRL = 32'd2; bus.CODEWORD_WIDTH = 32'd2;
    tick();
    bus.ctrl_wr = 1'b0; bus.enc_done = 1'b1;
    tick();
    bus.enc_done = 1'b0;
    repeat (3) tick();
    chk("mr_busy", bus.busy, 1'b1);
    chk("mr_src", bus.dec_src_sel, 1'b1);
    chk("mr_width", bus.width_sel, 2'b10);
    rst = 1'b1;
    tick();
    chk("mr_outs_zero", outs(), 12'h000);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.operation_done || bus.busy || bus.dec_start) bad++;
    end
    chk("mr_quiet", bad, 0);
    held_err = 2'b00;
    held_to  = 1'b0;
  endtask

  initial begin
    int op, wd, d1, d2;
    drive_zero();
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outs", outs(), 12'h000);
    rst = 1'b0;
    held_err = 2'b00;
    held_to  = 1'b0;

    idle_stray();
    run_op(0, 1, 4, 0, 0, 0, 2);      // encode, done 4 cycles late
    run_op(2, 2, 2, 3, 1, 0, 2);      // full channel
    run_op(1, 0, 0, 3, 2, 0, 2);      // decode only
    run_op(0, 3, 1000, 0, 0, 0, 2);   // encoder never answers
    run_op(3, 1, 0, 0, 0, 0, 2);      // illegal opcode, results held
    run_op(0, 0, 0, 0, 0, 0, 0);      // ideal latency, back-to-back next
    run_op(2, 1, 0, 0, 3, 0, 2);      // ideal full channel
    run_op(1, 2, 5, 8, 1, 2, 2);      // write during DEC refused
    run_op(0, 0, 63, 0, 0, 0, 1);     // done on the timeout cycle
    run_op(0, 0, 64, 0, 0, 0, 1);     // done one cycle too late
    run_op(1, 1, 0, 63, 2, 1, 1);
    run_op(2, 2, 1, 200, 0, 1, 1);    // decoder timeout in full channel
    idle_stray();
    mid_reset();
    run_op(0, 1, 2, 0, 0, 0, 2);

    for (int k = 0; k < 30; k++) begin
      op = $urandom_range(0, 3);
      wd = $urandom_range(0, 3);
      d1 = ($urandom_range(0, 9) == 0) ? $urandom_range(62, 70) : $urandom_range(0, 6);
      d2 = ($urandom_range(0, 9) == 0) ? $urandom_range(62, 70) : $urandom_range(0, 6);
      run_op(op, wd, d1, d2, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
